// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle FSM controller with PC sequencing and retired-instruction count
module multicycle_ctrl #(
  parameter logic [31:0] RESET_PC = 32'd128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ins,
  input  logic        zero,
  input  logic [31:0] imm,
  input  logic [31:0] jTarget,
  input  logic [31:0] PCp4,
  output logic [31:0] PCin,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        Mem2Reg,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [2:0]  op,
  output logic [2:0]  state,
  output logic        halted,
  output logic [31:0] retired
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LD = 7'h03,
                         OP_ST = 7'h23, OP_BR = 7'h63, OP_JAL = 7'h6F;
  state_t cur, nxt;
  logic [6:0] opc;
  logic [31:0] npc;
  logic legal, act, pc_upd, unused_ins;
  assign unused_ins = ^ins[31:7];
  assign legal = opc == OP_R || opc == OP_I || opc == OP_LD ||
                 opc == OP_ST || opc == OP_BR || opc == OP_JAL;
  assign pc_upd = (cur == EXEC && opc == OP_BR) || (cur == MEM && opc == OP_ST) || cur == WB;
  assign npc = (opc == OP_BR && zero) ? PCin + (imm << 1) :
               opc == OP_JAL ? PCin + (jTarget << 2) : PCp4;
  // next-state sequencing by latched opcode
  always_comb begin
    nxt = cur;
    case (cur)
      FETCH:  nxt = DECODE;
      DECODE: nxt = legal ? EXEC : HALT;
      EXEC:   nxt = (opc == OP_LD || opc == OP_ST) ? MEM : opc == OP_BR ? FETCH : WB;
      MEM:    nxt = opc == OP_LD ? WB : FETCH;
      WB:     nxt = FETCH;
      default: nxt = HALT;
    endcase
  end
  // Moore datapath controls; strobes only in EXEC/MEM/WB
  always_comb begin
    act      = cur == EXEC || cur == MEM || cur == WB;
    ALUSrc   = act && opc != OP_R && opc != OP_BR;
    op       = (act && opc == OP_BR) ? 3'b110 : 3'b010;
    MemRead  = cur == MEM && opc == OP_LD;
    MemWrite = cur == MEM && opc == OP_ST;
    Mem2Reg  = (cur == MEM || cur == WB) && opc == OP_LD;
    RegWrite = cur == WB;
    halted   = cur == HALT;
    state    = cur;
  end
  // state, opcode latch, PC and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= FETCH;
      opc     <= 7'd0;
      PCin    <= RESET_PC;
      retired <= 32'd0;
    end else begin
      cur <= nxt;
      if (cur == FETCH) opc <= ins[6:0];
      if (pc_upd) begin
        PCin    <= npc;
        retired <= retired + 32'd1;
      end
    end
  end
endmodule
